// File: rtl/uart_tx_framer.sv
// uart_tx_framer: drains an FWFT byte FIFO into 8-N-1 serial frames.
// Each packet is sent back-to-back, followed by an N-byte footer and then an idle gap.
// A packet can optionally be cut at a maximum payload length; the remaining bytes start the next packet.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   tx_data_in     FIFO head byte (first-word fall-through)
//   tx_valid_in    FIFO not empty
//   tx_ready_out   combinational read-enable; the byte is consumed on this edge
//   fpga_uart_tx   serial line, idles high
//   busy           high from the first byte accepted until the end of the gap
//   pkt_done       one-cycle pulse once the gap completes
//   pkt_len        payload byte count of the last packet, valid with pkt_done
module uart_tx_framer #(
    parameter int unsigned CLKS_PER_BIT  = 1736,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned FOOTER_BYTES  = 4,
    parameter logic [63:0] FOOTER_WORD   = 64'h00000000FFFFFFFF,
    parameter int unsigned MAX_PKT_BYTES = 0,
    parameter int unsigned GAP_BITS      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data_in,
    input  logic        tx_valid_in,
    output logic        tx_ready_out,
    output logic        fpga_uart_tx,
    output logic        busy,
    output logic        pkt_done,
    output logic [15:0] pkt_len
);

    // Frame: 1 start + 8 data + STOP_BITS stop bits
    localparam int unsigned FRAME_BITS = 9 + STOP_BITS;
    localparam int unsigned BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST   = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        FOOTER = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // Serializer
    logic               ser_active;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [7:0]         shreg;
    logic               bit_end;
    logic               last_cycle;
    logic               slot_free;

    // Control from the next-state logic
    logic               ld;
    logic [7:0]         ld_byte;
    logic [CNT_W-1:0]   pay_cnt_q;
    logic [CNT_W-1:0]   pay_cnt_d;
    logic [IDX_W-1:0]   ftr_idx_q;
    logic [IDX_W-1:0]   ftr_idx_d;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_d;
    logic               busy_d;
    logic               done_d;
    logic [CNT_W-1:0]   len_d;
    logic               seg_hit;
    logic               end_pay;
    logic               to_gap;
    logic               finish;
    logic [7:0]         ftr_byte;

    // Slot is free when idle or on the very last cycle of the final stop bit
    assign bit_end    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_cycle = ser_active && bit_end && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign slot_free  = !ser_active || last_cycle;

    // Footer byte i lives at FOOTER_WORD[8i+7:8i]
    assign ftr_byte = FOOTER_WORD[{ftr_idx_q[2:0], 3'b000} +: 8];

    // Forced segmentation only when a maximum length is configured
    assign seg_hit = (MAX_PKT_BYTES != 0) && (pay_cnt_q == CNT_W'(MAX_PKT_BYTES));

    // Serializer: start bit on the cycle after load, LSB first, stop bits shifted in as ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_active   <= 1'b0;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= 8'hFF;
            fpga_uart_tx <= 1'b1;
        end else if (ld) begin
            ser_active   <= 1'b1;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= ld_byte;
            fpga_uart_tx <= 1'b0;
        end else if (ser_active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                    ser_active   <= 1'b0;
                    fpga_uart_tx <= 1'b1;
                end else begin
                    bit_cnt      <= bit_cnt + BIT_W'(1);
                    fpga_uart_tx <= shreg[0];
                    shreg        <= {1'b1, shreg[7:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end
        end
    end

    // Packet state register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pay_cnt_q <= '0;
            ftr_idx_q <= '0;
            gap_cnt_q <= '0;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_len   <= '0;
        end else begin
            state_q   <= state_d;
            pay_cnt_q <= pay_cnt_d;
            ftr_idx_q <= ftr_idx_d;
            gap_cnt_q <= gap_cnt_d;
            busy      <= busy_d;
            pkt_done  <= done_d;
            pkt_len   <= len_d;
        end
    end

    // Next-state, handshake and serializer load decisions
    always_comb begin
        state_d      = state_q;
        tx_ready_out = 1'b0;
        ld           = 1'b0;
        ld_byte      = 8'hFF;
        pay_cnt_d    = pay_cnt_q;
        ftr_idx_d    = ftr_idx_q;
        gap_cnt_d    = gap_cnt_q;
        busy_d       = busy;
        done_d       = 1'b0;
        len_d        = pkt_len;
        end_pay      = 1'b0;
        to_gap       = 1'b0;
        finish       = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid_in) begin
                    tx_ready_out = 1'b1;
                    ld           = 1'b1;
                    ld_byte      = tx_data_in;
                    pay_cnt_d    = CNT_W'(1);
                    busy_d       = 1'b1;
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (slot_free) begin
                    if (seg_hit) begin
                        end_pay = 1'b1;
                    end else if (tx_valid_in) begin
                        tx_ready_out = 1'b1;
                        ld           = 1'b1;
                        ld_byte      = tx_data_in;
                        if (pay_cnt_q != {CNT_W{1'b1}}) begin
                            pay_cnt_d = pay_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        end_pay = 1'b1;
                    end
                end
            end
            FOOTER: begin
                if (slot_free) begin
                    if (ftr_idx_q == IDX_W'(FOOTER_BYTES)) begin
                        to_gap = 1'b1;
                    end else begin
                        ld        = 1'b1;
                        ld_byte   = ftr_byte;
                        ftr_idx_d = ftr_idx_q + IDX_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    finish = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Footer byte 0 is loaded on the same slot-free cycle so it follows the payload without idle
        if (end_pay) begin
            if (FOOTER_BYTES != 0) begin
                ld        = 1'b1;
                ld_byte   = FOOTER_WORD[7:0];
                ftr_idx_d = IDX_W'(1);
                state_d   = FOOTER;
            end else begin
                to_gap = 1'b1;
            end
        end

        if (to_gap) begin
            if (GAP_CYCLES != 0) begin
                gap_cnt_d = '0;
                state_d   = GAP;
            end else begin
                finish = 1'b1;
            end
        end

        if (finish) begin
            done_d  = 1'b1;
            len_d   = pay_cnt_q;
            busy_d  = 1'b0;
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: four parameter sets, a byte-FIFO model, a mid-bit line decoder
// and scoreboard queues for line bytes and packet lengths.
module tb_uart_tx_framer;

    localparam int CPB = 8;
    localparam int NI  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vin  [NI];
    logic [7:0]  din  [NI];
    logic        rdy  [NI];
    logic        ln   [NI];
    logic        bsy  [NI];
    logic        dn   [NI];
    logic [15:0] plen [NI];

    always #5 clk = ~clk;

    uart_tx_framer #(.CLKS_PER_BIT(CPB)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data_in(din[0]), .tx_valid_in(vin[0]), .tx_ready_out(rdy[0]),
        .fpga_uart_tx(ln[0]), .busy(bsy[0]), .pkt_done(dn[0]), .pkt_len(plen[0]));
    uart_tx_framer #(.CLKS_PER_BIT(CPB), .FOOTER_BYTES(2), .FOOTER_WORD(64'h000000000000BEEF)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data_in(din[1]), .tx_valid_in(vin[1]), .tx_ready_out(rdy[1]),
        .fpga_uart_tx(ln[1]), .busy(bsy[1]), .pkt_done(dn[1]), .pkt_len(plen[1]));
    uart_tx_framer #(.CLKS_PER_BIT(CPB), .MAX_PKT_BYTES(4)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data_in(din[2]), .tx_valid_in(vin[2]), .tx_ready_out(rdy[2]),
        .fpga_uart_tx(ln[2]), .busy(bsy[2]), .pkt_done(dn[2]), .pkt_len(plen[2]));
    uart_tx_framer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data_in(din[3]), .tx_valid_in(vin[3]), .tx_ready_out(rdy[3]),
        .fpga_uart_tx(ln[3]), .busy(bsy[3]), .pkt_done(dn[3]), .pkt_len(plen[3]));

    int          checks;
    int          errors;
    int          cyc;
    int          sel;
    int          r0;
    bit          en;
    bit          pend;
    logic [7:0]  fifo      [$];
    logic [7:0]  exp_q     [$];
    logic [15:0] exp_len_q [$];
    int          rdy_q     [$];
    int          done_q    [$];
    int          start_q   [$];
    int          run_q     [$];
    int          brise_q   [$];
    bit          dec_on;
    int          dec_cnt;
    int          hi_run;
    logic [7:0]  dec_sh;
    bit          prev_busy;
    int          bad_rdy;
    int          fe_cnt;
    int          unexp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // One clock: FIFO update and drive at negedge, then sample DUT outputs 1 ns later
    task automatic step();
        logic o_rdy, o_line, o_busy, o_done;
        logic [15:0] o_len;
        int k;
        @(negedge clk);
        cyc++;
        if (pend) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pend = 1'b0;
        end
        for (int i = 0; i < NI; i++) begin
            vin[i] = 1'b0;
            din[i] = 8'h00;
        end
        if (en && fifo.size() > 0) begin
            vin[sel] = 1'b1;
            din[sel] = fifo[0];
        end
        #1;
        o_rdy  = rdy[sel];
        o_line = ln[sel];
        o_busy = bsy[sel];
        o_done = dn[sel];
        o_len  = plen[sel];

        if (o_rdy === 1'b1) begin
            if (vin[sel] !== 1'b1) bad_rdy++;
            pend = 1'b1;
            rdy_q.push_back(cyc);
        end
        if (o_busy === 1'b1 && !prev_busy) brise_q.push_back(cyc);
        prev_busy = (o_busy === 1'b1);

        if (o_done === 1'b1) begin
            done_q.push_back(cyc);
            if (exp_len_q.size() > 0) check("pkt_len", 32'(o_len), 32'(exp_len_q.pop_front()));
            else unexp++;
            check("busy_at_done", 32'(o_busy), 32'd0);
        end

        // Line decoder: sample each bit in its middle
        if (!dec_on && o_line === 1'b0) begin
            dec_on  = 1'b1;
            dec_cnt = 0;
            start_q.push_back(cyc);
            run_q.push_back(hi_run);
        end else if (dec_on) begin
            dec_cnt++;
        end
        hi_run = (o_line === 1'b1) ? hi_run + 1 : 0;
        if (dec_on && (dec_cnt % CPB) == CPB / 2) begin
            k = dec_cnt / CPB;
            if (k == 0) begin
                if (o_line !== 1'b0) fe_cnt++;
            end else if (k <= 8) begin
                dec_sh[k-1] = o_line;
            end else begin
                if (o_line !== 1'b1) fe_cnt++;
                dec_on = 1'b0;
                if (exp_q.size() > 0) check("line_byte", 32'(dec_sh), 32'(exp_q.pop_front()));
                else unexp++;
            end
        end
    endtask

    task automatic start_test(input int s);
        fifo.delete();
        exp_q.delete();
        exp_len_q.delete();
        rdy_q.delete();
        done_q.delete();
        start_q.delete();
        run_q.delete();
        brise_q.delete();
        dec_on    = 1'b0;
        dec_cnt   = 0;
        hi_run    = 0;
        pend      = 1'b0;
        prev_busy = 1'b0;
        en        = 1'b0;
        sel       = s;
    endtask

    task automatic wait_ready(input int max_cyc);
        int n = 0;
        while (rdy_q.size() == 0 && n < max_cyc) begin
            step();
            n++;
        end
        check("first_ready", 32'(rdy_q.size()), 32'd1);
        r0 = qat(rdy_q, 0);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || exp_len_q.size() != 0 || fifo.size() != 0) && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_len", 32'(exp_len_q.size()), 32'd0);
        check("drain_bytes", 32'(exp_q.size()), 32'd0);
        repeat (24) step();
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic push_ftr4();
        repeat (4) exp_q.push_back(8'hFF);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        bad_rdy = 0;
        fe_cnt  = 0;
        unexp   = 0;
        r0      = 0;
        dec_sh  = 8'h00;
        for (int i = 0; i < NI; i++) begin
            vin[i] = 1'b0;
            din[i] = 8'h00;
        end
        start_test(0);

        // Reset state of every instance
        rst_n = 1'b0;
        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            check("rst_line",  32'(ln[i]),   32'd1);
            check("rst_ready", 32'(rdy[i]),  32'd0);
            check("rst_busy",  32'(bsy[i]),  32'd0);
            check("rst_done",  32'(dn[i]),   32'd0);
            check("rst_len",   32'(plen[i]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) step();

        // 1: three bytes, default 4-byte FF footer, 2-bit gap
        start_test(0);
        fifo = '{8'hA5, 8'h3C, 8'h00};
        exp_q = '{8'hA5, 8'h3C, 8'h00};
        push_ftr4();
        exp_len_q.push_back(16'd3);
        en = 1'b1;
        wait_ready(50);
        drain(2000);
        check("t1_ready_cnt", 32'(rdy_q.size()), 32'd3);
        check("t1_pitch0", 32'(qat(rdy_q, 1) - qat(rdy_q, 0)), 32'(10 * CPB));
        check("t1_pitch1", 32'(qat(rdy_q, 2) - qat(rdy_q, 1)), 32'(10 * CPB));
        check("t1_start_lat", 32'(qat(start_q, 0)), 32'(r0 + 1));
        check("t1_busy_rise", 32'(qat(brise_q, 0)), 32'(r0 + 1));
        check("t1_done_cnt", 32'(done_q.size()), 32'd1);
        check("t1_done_time", 32'(qat(done_q, 0) - r0), 32'(7 * 10 * CPB + 2 * CPB + 1));

        // 2: single byte with a 2-byte BEEF footer, low byte first
        start_test(1);
        fifo = '{8'h81};
        exp_q = '{8'h81, 8'hEF, 8'hBE};
        exp_len_q.push_back(16'd1);
        en = 1'b1;
        wait_ready(50);
        drain(2000);
        check("t2_done_time", 32'(qat(done_q, 0) - r0), 32'(3 * 10 * CPB + 2 * CPB + 1));

        // 3: forced split at 4 payload bytes, remainder becomes the next packet
        start_test(2);
        fifo = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        push_ftr4();
        exp_q.push_back(8'h14);
        exp_q.push_back(8'h15);
        push_ftr4();
        exp_len_q.push_back(16'd4);
        exp_len_q.push_back(16'd2);
        en = 1'b1;
        wait_ready(50);
        drain(4000);
        check("t3_ready_cnt", 32'(rdy_q.size()), 32'd6);
        check("t3_pitch4", 32'(qat(rdy_q, 3) - qat(rdy_q, 0)), 32'(3 * 10 * CPB));
        check("t3_done0_time", 32'(qat(done_q, 0) - r0), 32'(8 * 10 * CPB + 2 * CPB + 1));
        check("t3_resume", 32'(qat(rdy_q, 4)), 32'(qat(done_q, 0)));

        // 4: two stop bits; 0x55 ends on a 0 data bit so the high run is just the stop bits
        start_test(3);
        fifo = '{8'h55, 8'h2A};
        exp_q = '{8'h55, 8'h2A};
        push_ftr4();
        exp_len_q.push_back(16'd2);
        en = 1'b1;
        wait_ready(50);
        drain(2000);
        check("t4_start_pitch", 32'(qat(start_q, 1) - qat(start_q, 0)), 32'(11 * CPB));
        check("t4_stop_run", 32'(qat(run_q, 1)), 32'(2 * CPB));
        check("t4_done_time", 32'(qat(done_q, 0) - r0), 32'(6 * 11 * CPB + 2 * CPB + 1));

        // 5: data arriving 5 cycles into the gap waits for IDLE
        start_test(0);
        fifo = '{8'h42};
        exp_q = '{8'h42};
        push_ftr4();
        exp_q.push_back(8'h99);
        push_ftr4();
        exp_len_q.push_back(16'd1);
        exp_len_q.push_back(16'd1);
        en = 1'b1;
        wait_ready(50);
        step_to(r0 + 5 * 10 * CPB + 5);
        fifo.push_back(8'h99);
        drain(3000);
        check("t5_ready_cnt", 32'(rdy_q.size()), 32'd2);
        check("t5_done_time", 32'(qat(done_q, 0) - r0), 32'(5 * 10 * CPB + 2 * CPB + 1));
        check("t5_ready_at_idle", 32'(qat(rdy_q, 1)), 32'(qat(done_q, 0)));
        check("t5_start_after_done", 32'(qat(start_q, 5)), 32'(qat(done_q, 0) + 1));

        // 6a: reset in the middle of a data byte
        start_test(0);
        fifo = '{8'h11, 8'h22};
        en = 1'b1;
        wait_ready(50);
        step_to(r0 + 40);
        check("t6_pre_line_data", 32'(ln[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_line_data", 32'(ln[0]), 32'd1);
        check("t6_rst_busy_data", 32'(bsy[0]), 32'd0);
        start_test(0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 6b: reset in the middle of the first footer byte
        fifo = '{8'h33};
        exp_q = '{8'h33};
        en = 1'b1;
        wait_ready(50);
        step_to(r0 + 10 * CPB + 5);
        check("t6_payload_seen", 32'(exp_q.size()), 32'd0);
        check("t6_pre_line_ftr", 32'(ln[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_line_ftr", 32'(ln[0]), 32'd1);
        check("t6_rst_busy_ftr", 32'(bsy[0]), 32'd0);
        start_test(0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 6c: next packet after reset is complete and counted from 1
        fifo = '{8'h44, 8'h55};
        exp_q = '{8'h44, 8'h55};
        push_ftr4();
        exp_len_q.push_back(16'd2);
        en = 1'b1;
        wait_ready(50);
        drain(2000);
        check("t6_done_cnt", 32'(done_q.size()), 32'd1);
        check("t6_start_lat", 32'(qat(start_q, 0)), 32'(r0 + 1));

        check("ready_without_valid", 32'(bad_rdy), 32'd0);
        check("frame_errors", 32'(fe_cnt), 32'd0);
        check("unexpected_output", 32'(unexp), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
